// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: divides scki into bck, sequences lrck slots and shifts stereo frames out.
// Optional saturating underrun counter output is enabled by defining I2S_UNDERRUN_CNT_EN.
module i2s_tx_ctrl #(
    parameter int DW           = 16,
    parameter int SLOT_BITS    = 32,
    parameter int SCKI_PER_BCK = 4
) (
    input  logic          scki,
    input  logic          rst,
    input  logic          en,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_left,
    input  logic [DW-1:0] s_right,
    output logic          bck,
    output logic          lrck,
    output logic          adata,
    output logic          underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (SCKI_PER_BCK > 2) ? $clog2(SCKI_PER_BCK) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCKI_PER_BCK - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCKI_PER_BCK / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_BITS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    run_state_t             state_reg, state_next;
    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic                   bck_reg, bck_next;
    logic                   lrck_reg, lrck_next;
    logic                   adata_reg, adata_next;
    logic                   underrun_reg, underrun_next;
    logic                   s_ready_reg, s_ready_next;
    logic                   buf_full_reg, buf_full_next;
    logic [DW-1:0]          buf_left_reg, buf_right_reg;
    logic [FRAME_BITS-1:0]  frame_reg, frame_next;
    logic [FRAME_BITS-1:0]  frame_load;
    logic                   fall;
    logic                   boundary;
    logic                   transfer;

    // Frame bit k is the k-th bit shifted out: left MSB first, pad, then right MSB first, pad.
    generate
        for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_frame_map
            if (gi < DW) begin : g_left
                assign frame_load[gi] = buf_left_reg[DW-1-gi];
            end else if ((gi >= SLOT_BITS) && (gi < SLOT_BITS + DW)) begin : g_right
                assign frame_load[gi] = buf_right_reg[DW-1-(gi-SLOT_BITS)];
            end else begin : g_pad
                assign frame_load[gi] = 1'b0;
            end
        end
    endgenerate

    assign transfer = s_valid & s_ready_reg;

    always_comb begin
        state_next    = en ? ST_RUN : ST_IDLE;
        div_cnt_next  = div_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        bck_next      = bck_reg;
        lrck_next     = lrck_reg;
        adata_next    = adata_reg;
        frame_next    = frame_reg;
        fall          = 1'b0;
        boundary      = 1'b0;

        if (!en) begin
            div_cnt_next = '0;
            bit_cnt_next = '0;
            bck_next     = 1'b0;
            lrck_next    = 1'b0;
            adata_next   = 1'b0;
            frame_next   = '0;
        end else if (state_reg == ST_IDLE) begin
            // Starting up behaves like a frame wrap so the first frame is aligned to lrck.
            div_cnt_next = '0;
            bit_cnt_next = '0;
            bck_next     = 1'b0;
            lrck_next    = 1'b0;
            adata_next   = frame_reg[FRAME_BITS-1];
            boundary     = 1'b1;
        end else begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next = '0;
                fall         = 1'b1;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
            bck_next = (div_cnt_next >= DIV_HALF);

            if (fall) begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    boundary     = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                end
                lrck_next = (bit_cnt_next >= BIT_RIGHT);
                // One bck of delay after the lrck edge: position 0 still carries the old frame's tail.
                if (bit_cnt_next == '0) begin
                    adata_next = frame_reg[FRAME_BITS-1];
                end else begin
                    adata_next = frame_reg[bit_cnt_next - BIT_W'(1)];
                end
            end
        end

        if (boundary) begin
            frame_next = buf_full_reg ? frame_load : '0;
        end
        underrun_next = boundary & ~buf_full_reg;

        buf_full_next = buf_full_reg;
        if (boundary) begin
            buf_full_next = 1'b0;
        end
        if (transfer) begin
            buf_full_next = 1'b1;
        end
        s_ready_next = ~buf_full_next;
    end

    always_ff @(posedge scki) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            bck_reg       <= 1'b0;
            lrck_reg      <= 1'b0;
            adata_reg     <= 1'b0;
            underrun_reg  <= 1'b0;
            s_ready_reg   <= 1'b0;
            buf_full_reg  <= 1'b0;
            buf_left_reg  <= '0;
            buf_right_reg <= '0;
            frame_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            bck_reg       <= bck_next;
            lrck_reg      <= lrck_next;
            adata_reg     <= adata_next;
            underrun_reg  <= underrun_next;
            s_ready_reg   <= s_ready_next;
            buf_full_reg  <= buf_full_next;
            frame_reg     <= frame_next;
            if (transfer) begin
                buf_left_reg  <= s_left;
                buf_right_reg <= s_right;
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge scki) begin
        if (rst) begin
            underrun_cnt_reg <= '0;
        end else if (underrun_next && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_reg;
`endif

    assign s_ready  = s_ready_reg;
    assign bck      = bck_reg;
    assign lrck     = lrck_reg;
    assign adata    = adata_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: frame-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i2s_tx_ctrl;

    localparam int DW = 16;
    localparam int S  = 32;
    localparam int N  = 4;
    localparam int P  = N * 2 * S;

    logic        scki = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        bck, lrck, adata, underrun;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    i2s_tx_ctrl #(.DW(DW), .SLOT_BITS(S), .SCKI_PER_BCK(N)) dut (
        .scki     (scki),
        .rst      (rst),
        .en       (en),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bck      (bck),
        .lrck     (lrck),
        .adata    (adata),
        .underrun (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial forever #5 scki = ~scki;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t got timeout expected event", name, $time);
    endtask

    // ---------------- reference model: time since last frame boundary ----------------
    int          m_t = 0;
    bit          m_run = 0;
    bit          m_buf_v = 0;
    bit          m_ready = 0;
    bit          m_under = 0;
    int          m_cnt = 0;
    logic [15:0] m_buf_l = '0, m_buf_r = '0;
    logic [15:0] m_cur_l = '0, m_cur_r = '0;
    logic [15:0] m_prev_l = '0, m_prev_r = '0;

    function automatic logic frame_bit(input logic [15:0] l, input logic [15:0] r, input int j);
        if (j < DW) return l[DW-1-j];
        if (j >= S && j < S + DW) return r[DW-1-(j-S)];
        return 1'b0;
    endfunction

    task automatic model_step();
        bit xfer;
        bit bnd;
        if (rst) begin
            m_t = 0; m_run = 0; m_buf_v = 0; m_ready = 0; m_under = 0; m_cnt = 0;
            m_cur_l = '0; m_cur_r = '0; m_prev_l = '0; m_prev_r = '0;
            return;
        end
        xfer = s_valid && m_ready;
        bnd  = 0;
        if (!en) begin
            m_run = 0; m_t = 0; m_cur_l = '0; m_cur_r = '0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0; bnd = 1;
        end else begin
            m_t = (m_t + 1) % P;
            bnd = (m_t == 0);
        end
        m_under = bnd && !m_buf_v;
        if (bnd) begin
            m_prev_l = m_cur_l; m_prev_r = m_cur_r;
            m_cur_l = m_buf_v ? m_buf_l : 16'h0;
            m_cur_r = m_buf_v ? m_buf_r : 16'h0;
            m_buf_v = 0;
        end
        if (m_under && m_cnt < 65535) m_cnt++;
        if (xfer) begin
            m_buf_l = s_left; m_buf_r = s_right; m_buf_v = 1;
        end
        m_ready = !m_buf_v;
    endtask

    initial forever begin
        @(posedge scki);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        int  k;
        logic eb, el, ea;
        @(negedge scki);
        eb = 0; el = 0; ea = 0;
        if (m_run) begin
            k  = m_t / N;
            eb = (m_t % N) >= N / 2;
            el = k >= S;
            ea = (k == 0) ? frame_bit(m_prev_l, m_prev_r, 2 * S - 1) : frame_bit(m_cur_l, m_cur_r, k - 1);
        end
        chk("bck", bck, eb);
        chk("lrck", lrck, el);
        chk("adata", adata, ea);
        chk("underrun", underrun, m_under);
        chk("s_ready", s_ready, m_ready);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, 64'(m_cnt));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [15:0] l, input logic [15:0] r, output int stall);
        s_valid = 1; s_left = l; s_right = r; stall = 0;
        while (s_ready !== 1'b1 && stall < 3 * P) begin
            @(negedge scki);
            stall++;
        end
        if (s_ready !== 1'b1) timeout("push_ready");
        @(negedge scki);
        s_valid = 0;
        $display("push L=%h R=%h stall=%0d t=%0t", l, r, stall, $time);
    endtask

    task automatic wait_model(input logic [15:0] l, input logic [15:0] r, input int tt, input string name);
        int w;
        w = 0;
        while (!(m_run && m_cur_l == l && m_cur_r == r && m_t == tt) && w < 4 * P) begin
            @(negedge scki);
            w++;
        end
        if (w >= 4 * P) timeout(name);
    endtask

    initial begin
        int          stall;
        int          w;
        int          c;
        int          ones;
        int          pulses;
        logic        prev;
        logic [63:0] cap;

        // 1: reset
        rst = 1; en = 0;
        repeat (3) @(negedge scki);
        chk("rst_bck", bck, 1'b0);
        chk("rst_lrck", lrck, 1'b0);
        chk("rst_adata", adata, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        rst = 0;
        @(negedge scki);
        chk("post_rst_s_ready", s_ready, 1'b1);

        // 2: clock shapes
        en = 1;
        prev = lrck; w = 0;
        do begin prev = lrck; @(negedge scki); w++; end while (!(prev == 0 && lrck == 1) && w < 3 * P);
        if (w >= 3 * P) timeout("lrck_rise");
        c = 0;
        do begin prev = lrck; @(negedge scki); c++; end while (!(prev == 0 && lrck == 1) && c < 3 * P);
        chk("lrck_period", 64'(c), 64'd256);
        w = 0;
        do begin prev = bck; @(negedge scki); w++; end while (!(prev == 0 && bck == 1) && w < 20);
        c = 0;
        while (bck == 1 && c < 20) begin @(negedge scki); c++; end
        chk("bck_high", 64'(c), 64'd2);
        c = 0;
        while (bck == 0 && c < 20) begin @(negedge scki); c++; end
        chk("bck_low", 64'(c), 64'd2);

        // 3: bit layout
        push(16'hA5F0, 16'h0001, stall);
        wait_model(16'hA5F0, 16'h0001, 0, "t3_load");
        cap = '0;
        for (int cc = 1; cc <= 64 * N + N / 2; cc++) begin
            @(negedge scki);
            if ((cc % N) == N / 2 && cc >= N + N / 2) cap = {cap[62:0], adata};
        end
        chk("t3_frame_bits", cap, 64'hA5F0_0000_0001_0000);

        // 4: back-to-back pushes while idle
        push(16'h8001, 16'h7FFE, stall);
        chk("t4_ready_low", s_ready, 1'b0);
        push(16'h4BAD, 16'hC3C3, stall);
        chk("t4_second_stalled", 64'(stall > 0), 64'd1);
        wait_model(16'h8001, 16'h7FFE, N + N / 2, "t4_a");
        chk("t4_a_bit0", adata, 1'b1);
        @(negedge scki); @(negedge scki); @(negedge scki); @(negedge scki);
        chk("t4_a_bit1", adata, 1'b0);
        wait_model(16'h4BAD, 16'hC3C3, 2 * N + N / 2, "t4_b");
        chk("t4_b_bit1", adata, 1'b1);

        // 6: reset mid-frame with a frame buffered
        push(16'h1234, 16'hFEDC, stall);
        push(16'h5555, 16'hAAAA, stall);
        wait_model(16'h1234, 16'hFEDC, 20 * N + 1, "t6_bit20");
        rst = 1;
        @(negedge scki);
        chk("t6_bck", bck, 1'b0);
        chk("t6_lrck", lrck, 1'b0);
        chk("t6_adata", adata, 1'b0);
        chk("t6_underrun", underrun, 1'b0);
        chk("t6_s_ready", s_ready, 1'b0);
        rst = 0;
        @(negedge scki);
        chk("t6_restart_underrun", underrun, 1'b1);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("t5_cnt1", underrun_cnt, 64'd1);
`endif

        // 5: starved for further frames
        for (int i = 2; i <= 3; i++) begin
            ones = 0; pulses = 0;
            repeat (P - 1) begin
                @(negedge scki);
                ones += int'(adata);
                pulses += int'(underrun);
            end
            @(negedge scki);
            chk("t5_adata_ones", 64'(ones), 64'd0);
            chk("t5_no_extra_pulse", 64'(pulses), 64'd0);
            chk("t5_underrun", underrun, 1'b1);
`ifdef I2S_UNDERRUN_CNT_EN
            chk("t5_cnt", underrun_cnt, 64'(i));
`endif
        end

        // 7: randomized traffic, enable toggles and one reset
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(negedge scki);
            s_valid = ($urandom_range(0, 999) < ((cyc < 4500) ? 20 : 3));
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            if (en && $urandom_range(0, 1999) == 0) en = 0;
            else if (!en && $urandom_range(0, 29) == 0) en = 1;
            rst = (cyc == 6000);
        end
        s_valid = 0;
        repeat (4) @(negedge scki);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
